per_bus_arb: RTL
================

# per_bus_arb

Two-master arbiter for the 16-bit peripheral register bus. It accepts word accesses from two requesters, such as the CPU frontend (master 0) and a DMA or debug master (master 1). It serializes them onto the single shared per_addr/per_din/per_en/per_wen/per_dout bus and returns read data and completion to the winning master. Arbitration is round-robin by default, and every access is exactly one per_en cycle.

## Interface
- FIXED_PRIO, default 0: 0 selects round-robin; 1 selects fixed priority, where master 0 always wins a tie.

Ports:
- mclk  in  1  main system clock; all state changes on rising edge
- puc_n  in  1  reset, asynchronous, active-low
- m0_req  in  1  master 0 access request; held with its fields until m0_gnt
- m0_addr  in  8  master 0 word address
- m0_din  in  16  master 0 write data
- m0_wen  in  2  master 0 byte write enables; 2'b00 means read
- m0_gnt  out  1  master 0 access in progress on bus; one cycle
- m0_rdy  out  1  master 0 access complete; one-cycle pulse
- m0_dout  out  16  master 0 read data, valid from m0_rdy and held
- m1_req, m1_addr, m1_din, m1_wen, m1_gnt, m1_rdy, m1_dout  same as master 0
- per_addr  out  8  peripheral address
- per_din  out  16  peripheral write data
- per_en  out  1  peripheral enable, high active
- per_wen  out  2  peripheral write enables, high active
- per_dout  in  16  OR-combined peripheral read data; combinational, valid while per_en is high

## Operation
FSM states:
- IDLE: no access pending.
- ACCESS: the bus cycle; per_en=1.
- DONE: completion cycle; rdy pulses.

Transitions:
- IDLE: if any req is high, run arbitration, latch the winner's addr/din/wen and id, go to ACCESS. Otherwise stay in IDLE.
- ACCESS: always go to DONE.
- DONE: if any req is high, arbitrate and go to ACCESS (back-to-back). Otherwise go to IDLE.

Arbitration:
- One requester: that master wins.
- Both requesting, FIXED_PRIO=0: the master not served last wins. The last-served pointer updates on every grant and resets to 1, so master 0 wins the first tie.
- Both requesting, FIXED_PRIO=1: master 0 wins.

Bus outputs:
- Driven from the latched registers only in ACCESS: per_en=1, per_addr/per_din/per_wen = latched values.
- Outside ACCESS, per_en, per_addr, per_din and per_wen are all 0.

Grant and completion:
- mX_gnt=1 exactly during the ACCESS cycle of master X's access.
- The master keeps req/addr/din/wen stable until it samples gnt. In the cycle after gnt, req means a new request.
- mX_rdy=1 exactly during the DONE cycle following master X's ACCESS.

Read data:
- Read (latched wen==0): per_dout is captured into mX_dout at the end of ACCESS. The value is held until master X's next read completes.
- Writes never modify mX_dout.

Reset:
- Asserting puc_n low at any time, including mid-access, forces IDLE and pointer=1.
- All outputs go to 0: gnt, rdy, per_en, per_addr, per_din, per_wen, m0_dout, m1_dout.
- An access aborted by reset is not completed; no rdy is issued.

## Timing
- Request to per_en: 1 cycle (req sampled at edge N, per_en during cycle N+1).
- Request to rdy: 2 cycles; read data is valid on mX_dout in the same cycle as rdy.
- Throughput: one access every 2 cycles under continuous requests (ACCESS/DONE alternating). The other master waits at most one access under round-robin.
- gnt and rdy are registered state decodes; no combinational path from any req to any output.
- per_en is never high on two consecutive cycles.
- A requester that drops req before being granted is not served.

## Test plan
- Reset: drive puc_n=0 with random inputs -> all outputs 0. Release reset, then m0 reads addr 8'hC8 with per_dout=16'hA5A5 during per_en -> per_en high 1 cycle after req, per_addr=8'hC8, per_wen=0, m0_gnt in same cycle, m0_rdy next cycle with m0_dout=16'hA5A5.
- Write: m1 writes 16'h1234 to 8'hCA with wen=2'b11 -> per_din=16'h1234, per_wen=2'b11 for one cycle, m1_rdy pulse, m1_dout unchanged.
- Round-robin: both masters request continuously for 6 accesses -> grant order m0,m1,m0,m1,m0,m1, per_en every other cycle.
- FIXED_PRIO=1: both request continuously -> m0 granted every time, m1 never granted while m0_req held; m1 served in the first arbitration after m0_req drops.
- Reset mid-access: assert puc_n low during ACCESS -> per_en drops immediately, no rdy is issued afterwards, state IDLE. After release, a tie grants m0.
- Read-data hold: m0 reads 16'h00FF, then m0 writes, then m1 reads 16'hFFFF -> m0_dout stays 16'h00FF throughout.

Source files
------------

// File: rtl/per_bus_arb.sv
// rtl/per_bus_arb.sv - two-master arbiter serializing word accesses onto the peripheral register bus
module per_bus_arb #(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic        mclk,
  input  logic        puc_n,
  input  logic        m0_req,
  input  logic [7:0]  m0_addr,
  input  logic [15:0] m0_din,
  input  logic [1:0]  m0_wen,
  output logic        m0_gnt,
  output logic        m0_rdy,
  output logic [15:0] m0_dout,
  input  logic        m1_req,
  input  logic [7:0]  m1_addr,
  input  logic [15:0] m1_din,
  input  logic [1:0]  m1_wen,
  output logic        m1_gnt,
  output logic        m1_rdy,
  output logic [15:0] m1_dout,
  output logic [7:0]  per_addr,
  output logic [15:0] per_din,
  output logic        per_en,
  output logic [1:0]  per_wen,
  input  logic [15:0] per_dout
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic        any_req;
  logic        win_id;
  logic        arb_go;
  logic        last_id;
  logic        lat_id;
  logic [7:0]  lat_addr;
  logic [15:0] lat_din;
  logic [1:0]  lat_wen;

  // Pick the winner among current requesters; ties go to the master not served last
  always_comb begin
    any_req = m0_req | m1_req;
    win_id  = 1'b0;
    if (m0_req && m1_req) begin
      win_id = FIXED_PRIO ? 1'b0 : ~last_id;
    end else begin
      win_id = m1_req;
    end
    arb_go = any_req && (state != ACCESS);
  end

  // Next-state logic and registered-state output decodes
  always_comb begin
    state_nxt = state;
    m0_gnt    = 1'b0;
    m1_gnt    = 1'b0;
    m0_rdy    = 1'b0;
    m1_rdy    = 1'b0;
    per_en    = 1'b0;
    per_addr  = 8'h00;
    per_din   = 16'h0000;
    per_wen   = 2'b00;
    case (state)
      IDLE: begin
        if (any_req) state_nxt = ACCESS;
      end
      ACCESS: begin
        state_nxt = DONE;
        per_en    = 1'b1;
        per_addr  = lat_addr;
        per_din   = lat_din;
        per_wen   = lat_wen;
        m0_gnt    = ~lat_id;
        m1_gnt    = lat_id;
      end
      DONE: begin
        state_nxt = any_req ? ACCESS : IDLE;
        m0_rdy    = ~lat_id;
        m1_rdy    = lat_id;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register; reset aborts any access in flight
  always_ff @(posedge mclk or negedge puc_n) begin
    if (!puc_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Latch the winner's access fields and remember who was served last
  always_ff @(posedge mclk or negedge puc_n) begin
    if (!puc_n) begin
      last_id  <= 1'b1;
      lat_id   <= 1'b0;
      lat_addr <= 8'h00;
      lat_din  <= 16'h0000;
      lat_wen  <= 2'b00;
    end else if (arb_go) begin
      last_id  <= win_id;
      lat_id   <= win_id;
      lat_addr <= win_id ? m1_addr : m0_addr;
      lat_din  <= win_id ? m1_din : m0_din;
      lat_wen  <= win_id ? m1_wen : m0_wen;
    end
  end

  // Capture read data at the end of the bus cycle; writes leave dout untouched
  always_ff @(posedge mclk or negedge puc_n) begin
    if (!puc_n) begin
      m0_dout <= 16'h0000;
      m1_dout <= 16'h0000;
    end else if ((state == ACCESS) && (lat_wen == 2'b00)) begin
      if (lat_id) begin
        m1_dout <= per_dout;
      end else begin
        m0_dout <= per_dout;
      end
    end
  end

endmodule
